// File: rtl/edge_detect_unit.sv
// Conditions an asynchronous level input: 2-FF synchronizer, debounce filter and edge detector,
// plus saturating per-polarity edge counters and sticky edge flags.
module edge_detect_unit #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr,
  output logic             level,
  output logic             pos_edge,
  output logic             neg_edge,
  output logic             any_edge,
  output logic [CNT_W-1:0] pos_cnt,
  output logic [CNT_W-1:0] neg_cnt,
  output logic             pos_seen,
  output logic             neg_seen
);

  localparam int unsigned DbW = $clog2(DEBOUNCE + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic           s1, s2;
  logic           db, db_d;
  logic           db_q;
  logic [DbW-1:0] db_cnt, db_cnt_d;
  logic [CNT_W-1:0] pos_cnt_d, neg_cnt_d;
  logic           pos_seen_d, neg_seen_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // The level only follows s2 after it has disagreed for DEBOUNCE consecutive cycles.
  always_comb begin
    db_d     = db;
    db_cnt_d = db_cnt;
    if (s2 == db) begin
      db_cnt_d = '0;
    end else if (db_cnt == DbLast) begin
      db_d     = s2;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt + DbW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db     <= 1'b0;
      db_cnt <= '0;
      db_q   <= 1'b0;
    end else begin
      db     <= db_d;
      db_cnt <= db_cnt_d;
      db_q   <= db;
    end
  end

  assign level    = db;
  assign pos_edge = db & ~db_q;
  assign neg_edge = ~db & db_q;
  assign any_edge = pos_edge | neg_edge;

  // clr beats a same-cycle increment, but a same-cycle edge beats clr on the sticky flags.
  always_comb begin
    pos_cnt_d  = pos_cnt;
    neg_cnt_d  = neg_cnt;
    pos_seen_d = pos_seen;
    neg_seen_d = neg_seen;
    if (clr) begin
      pos_cnt_d = '0;
      neg_cnt_d = '0;
    end else begin
      if (pos_edge && (pos_cnt != CntMax)) pos_cnt_d = pos_cnt + CNT_W'(1);
      if (neg_edge && (neg_cnt != CntMax)) neg_cnt_d = neg_cnt + CNT_W'(1);
    end
    if (pos_edge) begin
      pos_seen_d = 1'b1;
    end else if (clr) begin
      pos_seen_d = 1'b0;
    end
    if (neg_edge) begin
      neg_seen_d = 1'b1;
    end else if (clr) begin
      neg_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_cnt  <= '0;
      neg_cnt  <= '0;
      pos_seen <= 1'b0;
      neg_seen <= 1'b0;
    end else begin
      pos_cnt  <= pos_cnt_d;
      neg_cnt  <= neg_cnt_d;
      pos_seen <= pos_seen_d;
      neg_seen <= neg_seen_d;
    end
  end

endmodule

// File: tb/tb_edge_detect_unit.sv
// Randomized and directed bench for edge_detect_unit, checked against a sliding-window model.
module tb_edge_detect_unit;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4;
  localparam int MaxCnt = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic clr = 1'b0;
  logic din1 = 1'b0;

  logic         level, pos_edge, neg_edge, any_edge, pos_seen, neg_seen;
  logic [W-1:0] pos_cnt, neg_cnt;
  logic         level1, pos1, neg1, any1, pseen1, nseen1;
  logic [W-1:0] pcnt1, ncnt1;

  always #5 clk = ~clk;

  edge_detect_unit #(.DEBOUNCE(D), .CNT_W(W)) u_dut (
    .clk(clk), .rst(rst), .din(din), .clr(clr), .level(level), .pos_edge(pos_edge),
    .neg_edge(neg_edge), .any_edge(any_edge), .pos_cnt(pos_cnt), .neg_cnt(neg_cnt),
    .pos_seen(pos_seen), .neg_seen(neg_seen)
  );

  edge_detect_unit #(.DEBOUNCE(1), .CNT_W(W)) u_dut1 (
    .clk(clk), .rst(rst), .din(din1), .clr(1'b0), .level(level1), .pos_edge(pos1),
    .neg_edge(neg1), .any_edge(any1), .pos_cnt(pcnt1), .neg_cnt(ncnt1),
    .pos_seen(pseen1), .neg_seen(nseen1)
  );

  always @(negedge clk) begin
    if (!rst) begin
      assert (any_edge == (pos_edge | neg_edge));
      assert (!(pos_edge && neg_edge));
      assert (any1 == (pos1 | neg1));
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: db flips when the last D synchronized samples all disagree with it.
  bit smp[$];
  bit win[$];
  bit m_db, m_dbq, m_pseen, m_nseen;
  int m_pcnt, m_ncnt;
  int obs_pos, obs_neg;

  function automatic void model_reset();
    smp = {1'b0, 1'b0};
    win = {};
    m_db = 0; m_dbq = 0; m_pseen = 0; m_nseen = 0;
    m_pcnt = 0; m_ncnt = 0;
  endfunction

  task automatic check_all(input string ph);
    bit p, n;
    p = m_db && !m_dbq;
    n = !m_db && m_dbq;
    check_eq({ph, ":level"}, int'(level), int'(m_db));
    check_eq({ph, ":pos_edge"}, int'(pos_edge), int'(p));
    check_eq({ph, ":neg_edge"}, int'(neg_edge), int'(n));
    check_eq({ph, ":any_edge"}, int'(any_edge), int'(p | n));
    check_eq({ph, ":pos_cnt"}, int'(pos_cnt), m_pcnt);
    check_eq({ph, ":neg_cnt"}, int'(neg_cnt), m_ncnt);
    check_eq({ph, ":pos_seen"}, int'(pos_seen), int'(m_pseen));
    check_eq({ph, ":neg_seen"}, int'(neg_seen), int'(m_nseen));
  endtask

  task automatic step(input string ph, input bit d, input bit c);
    bit p, n, s2b, all_diff;
    din = d;
    clr = c;
    @(posedge clk);
    p = m_db && !m_dbq;
    n = !m_db && m_dbq;
    if (c) begin
      m_pcnt = 0;
      m_ncnt = 0;
    end else begin
      if (p) m_pcnt = (m_pcnt + 1 > MaxCnt) ? MaxCnt : m_pcnt + 1;
      if (n) m_ncnt = (m_ncnt + 1 > MaxCnt) ? MaxCnt : m_ncnt + 1;
    end
    m_pseen = p ? 1'b1 : (c ? 1'b0 : m_pseen);
    m_nseen = n ? 1'b1 : (c ? 1'b0 : m_nseen);
    s2b = smp[1];
    win.push_back(s2b);
    if (win.size() > D) void'(win.pop_front());
    all_diff = (win.size() == D);
    foreach (win[i]) if (win[i] == m_db) all_diff = 0;
    m_dbq = m_db;
    if (all_diff) m_db = !m_db;
    smp.push_front(d);
    void'(smp.pop_back());
    #1;
    check_all(ph);
    if (pos_edge) obs_pos++;
    if (neg_edge) obs_neg++;
    clr = 1'b0;
  endtask

  initial begin
    int n, run, base_p;
    bit din_r;
    model_reset();
    #3;
    check_all("reset");
    check_eq("reset:level1", int'(level1), 0);
    #20;
    rst = 1'b0;
    repeat (3) step("idle", 0, 0);

    // Basic rise: pulse appears after the sixth edge counting the sampling edge.
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step("rise", 1, 0);
      if (pos_edge) begin n = i; break; end
    end
    check_eq("rise_latency", n, 6);
    step("rise", 1, 0);
    check_eq("rise_single", int'(pos_edge), 0);
    check_eq("rise_pcnt", int'(pos_cnt), 1);
    check_eq("rise_pseen", int'(pos_seen), 1);
    check_eq("rise_nseen", int'(neg_seen), 0);
    repeat (8) step("fall", 0, 0);

    // Glitch rejection, then a just-long-enough pulse.
    base_p = int'(pos_cnt);
    obs_pos = 0; obs_neg = 0;
    repeat (3) step("glitch", 1, 0);
    repeat (10) step("glitch", 0, 0);
    check_eq("glitch_pulses", obs_pos, 0);
    check_eq("glitch_level", int'(level), 0);
    check_eq("glitch_pcnt", int'(pos_cnt), base_p);
    repeat (4) step("pulse4", 1, 0);
    repeat (10) step("pulse4", 0, 0);
    check_eq("pulse4_pos", obs_pos, 1);
    check_eq("pulse4_neg", obs_neg, 1);

    // Saturation.
    step("sat", 0, 1);
    for (int i = 0; i < 20; i++) begin
      repeat (6) step("sat", 1, 0);
      repeat (6) step("sat", 0, 0);
    end
    check_eq("sat_pcnt", int'(pos_cnt), MaxCnt);
    check_eq("sat_ncnt", int'(neg_cnt), MaxCnt);

    // clr in the same cycle as pos_edge.
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step("clrcol", 1, 0);
      if (pos_edge) begin n = i; break; end
    end
    check_eq("clrcol_found", n, 6);
    step("clrcol", 1, 1);
    check_eq("clrcol_pcnt", int'(pos_cnt), 0);
    check_eq("clrcol_pseen", int'(pos_seen), 1);
    repeat (8) step("clrcol", 0, 0);

    // Reset in the middle of a debounce.
    repeat (2) step("rstmid", 1, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    #2 rst = 1'b0;
    obs_pos = 0;
    repeat (12) step("rstrel", 1, 0);
    check_eq("rstrel_pulses", obs_pos, 1);

    // DEBOUNCE=1 instance latency.
    n = 0;
    din1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step("d1", 1, 0);
      if (pos1) begin n = i; break; end
    end
    check_eq("d1_rise_latency", n, 3);
    step("d1", 1, 0);
    check_eq("d1_rise_single", int'(pos1), 0);
    check_eq("d1_level", int'(level1), 1);
    n = 0;
    din1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step("d1", 1, 0);
      if (neg1) begin n = i; break; end
    end
    check_eq("d1_fall_latency", n, 3);
    check_eq("d1_pcnt", int'(pcnt1), 1);

    // Randomized run lengths and sporadic clr.
    din_r = 1'b1;
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        din_r = !din_r;
        run = $urandom_range(1, 8);
      end
      step("rand", din_r, $urandom_range(0, 15) == 0);
      run--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
